// File: rtl/acum_seq_ctrl.sv
// Accumulation-buffer sequencer for one GEMM output tile.
// Pass 0 overwrites partial sums, middle passes accumulate, and the final pass
// accumulates and stores finished rows into the show-ahead output buffer, which
// drains to the consumer while the tile is still running.
module acum_seq_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned RW    = 5,
  parameter int unsigned KW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] cfg_rows,
  input  logic [KW-1:0] cfg_passes,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          buf_valid,
  output logic          buf_store,
  output logic          buf_overwrite,
  input  logic          buf_empty,
  output logic          buf_rd_en,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [RW-1:0] MaxRows = RW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e        state_q;
  logic [RW-1:0] rows_q, row_cnt_q, ob_cnt_q;
  logic [KW-1:0] passes_q, pass_cnt_q;
  logic          cfg_err_q;

  logic accept, last_row, last_pass, cfg_ok, ob_inc, ob_dec, drained;

  // Handshake decode and per-row buffer controls, all from registered state.
  always_comb begin
    in_ready      = (state_q == StAccum);
    busy          = (state_q != StIdle);
    accept        = in_valid & in_ready;
    last_row      = (row_cnt_q == rows_q - 1'b1);
    last_pass     = (pass_cnt_q == passes_q - 1'b1);
    buf_valid     = accept;
    buf_overwrite = accept & (pass_cnt_q == '0);
    buf_store     = accept & last_pass;
    out_valid     = ~buf_empty;
    buf_rd_en     = out_valid & out_ready;
    ob_inc        = buf_valid & buf_store;
    ob_dec        = buf_rd_en;
    drained       = (ob_cnt_q == '0);
    done          = (state_q == StDrain) & drained;
    cfg_ok        = (cfg_rows != '0) && (cfg_rows <= MaxRows) && (cfg_passes != '0);
    cfg_err       = cfg_err_q;
  end

  // Tile FSM, row/pass counters and output-buffer occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rows_q     <= '0;
      passes_q   <= '0;
      row_cnt_q  <= '0;
      pass_cnt_q <= '0;
      ob_cnt_q   <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      // A store and a pop in the same cycle cancel out.
      if (ob_inc && !ob_dec) begin
        ob_cnt_q <= ob_cnt_q + 1'b1;
      end else if (ob_dec && !ob_inc) begin
        ob_cnt_q <= ob_cnt_q - 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_ok) begin
              rows_q     <= cfg_rows;
              passes_q   <= cfg_passes;
              row_cnt_q  <= '0;
              pass_cnt_q <= '0;
              ob_cnt_q   <= '0;
              state_q    <= StAccum;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            if (last_row) begin
              row_cnt_q <= '0;
              if (last_pass) begin
                state_q <= StDrain;
              end else begin
                pass_cnt_q <= pass_cnt_q + 1'b1;
              end
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drained) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acum_seq_ctrl.sv
// Self-checking bench for acum_seq_ctrl. The bench emulates the accumulation
// and output buffers (driven by the DUT's controls) and predicts every control
// output from the tile rules: accept k belongs to pass k/rows.
`timescale 1ns/1ps
module tb_acum_seq_ctrl;
  localparam int RW = 5;
  localparam int KW = 8;

  typedef logic [3:0][31:0] row_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] cfg_rows = '0;
  logic [KW-1:0] cfg_passes = '0;
  logic          busy, done, cfg_err, in_ready;
  logic          in_valid = 1'b0;
  logic          buf_valid, buf_store, buf_overwrite, buf_rd_en, out_valid;
  logic          buf_empty = 1'b1;
  logic          out_ready = 1'b0;

  acum_seq_ctrl #(.DEPTH(16), .RW(RW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_passes(cfg_passes),
    .busy(busy), .done(done), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .buf_valid(buf_valid), .buf_store(buf_store), .buf_overwrite(buf_overwrite),
    .buf_empty(buf_empty), .buf_rd_en(buf_rd_en), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   m_active = 0;
  bit   m_err = 0;
  int   m_rows = 0;
  int   m_passes = 0;
  int   k = 0;
  int   pops = 0;
  int   done_seen = 0;
  int   in_mode = 0;
  int   rdy_mode = 0;
  bit   tog = 1'b1;
  int   d0;
  row_t accq[$];
  row_t outq[$];
  row_t data_in[4][16];
  row_t first_pop;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic row_t add_rows(row_t a, row_t b);
    row_t r;
    for (int l = 0; l < 4; l++) r[l] = a[l] + b[l];
    return r;
  endfunction

  // Finished value of row r: lane-wise sum of that row's input over every pass.
  function automatic row_t exp_row(int r);
    row_t s = '0;
    for (int p = 0; p < m_passes; p++) s = add_rows(s, data_in[p & 3][r & 15]);
    return s;
  endfunction

  task automatic set_data();
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 16; r++)
        for (int l = 0; l < 4; l++) data_in[p][r][l] = 32'($urandom_range(0, 200)) - 32'd100;
  endtask

  // One clock: drive inputs after negedge, check at +1, update model at posedge.
  task automatic cycle();
    bit e_rdy, e_bv, e_ow, e_st, e_done, e_ov, e_rd, was_active;
    bit bv_a, ow_a, st_a, rd_a;
    int kp, kr, total;
    row_t v, d;
    case (in_mode)
      0: in_valid = 1'b1;
      1: begin in_valid = tog; tog = ~tog; end
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    buf_empty = (outq.size() == 0);
    #1;
    total  = m_rows * m_passes;
    kp     = (m_rows > 0) ? k / m_rows : 0;
    kr     = (m_rows > 0) ? k % m_rows : 0;
    e_rdy  = m_active && (k < total);
    e_bv   = e_rdy && in_valid;
    e_ow   = e_bv && (kp == 0);
    e_st   = e_bv && (kp == m_passes - 1);
    e_done = m_active && (k == total) && (outq.size() == 0);
    e_ov   = (outq.size() != 0);
    e_rd   = e_ov && out_ready;
    chk("in_ready", in_ready, e_rdy);
    chk("busy", busy, m_active);
    chk("buf_valid", buf_valid, e_bv);
    chk("buf_overwrite", buf_overwrite, e_ow);
    chk("buf_store", buf_store, e_st);
    chk("done", done, e_done);
    chk("cfg_err", cfg_err, m_err);
    chk("out_valid", out_valid, e_ov);
    chk("buf_rd_en", buf_rd_en, e_rd);
    bv_a = buf_valid; ow_a = buf_overwrite; st_a = buf_store; rd_a = buf_rd_en;
    if (done === 1'b1) done_seen++;
    was_active = m_active;
    @(posedge clk);
    m_err = 1'b0;
    if (rd_a && outq.size() > 0) begin
      v = outq.pop_front();
      chk("row_data", v, exp_row(pops));
      if (pops == 0) first_pop = v;
      pops++;
    end
    if (bv_a) begin
      d = data_in[kp & 3][kr & 15];
      if (ow_a) v = d;
      else if (accq.size() == 0) begin
        chk("acc_underflow", 1, 0);
        v = d;
      end else v = add_rows(accq.pop_front(), d);
      if (st_a) outq.push_back(v);
      else accq.push_back(v);
    end
    if (e_bv) k++;
    if (e_done) m_active = 1'b0;
    if (start && !was_active) begin
      if (cfg_rows != 0 && cfg_rows <= 16 && cfg_passes != 0) begin
        m_active = 1'b1;
        m_rows   = int'(cfg_rows);
        m_passes = int'(cfg_passes);
        k        = 0;
        pops     = 0;
      end else m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic start_tile(int r, int p);
    cfg_rows   = RW'(r);
    cfg_passes = KW'(p);
    start      = 1'b1;
    cycle();
    start      = 1'b0;
  endtask

  task automatic run_idle(int budget);
    int n = 0;
    while (m_active && n < budget) begin
      cycle();
      n++;
    end
    chk("tile_timeout", m_active, 0);
  endtask

  task automatic run_accepts(int target, int budget);
    int n = 0;
    while (k < target && n < budget) begin
      cycle();
      n++;
    end
    chk("accept_timeout", k, target);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    // S1: rows=4, passes=3, continuous input, consumer always ready
    in_mode = 0; rdy_mode = 0;
    set_data();
    data_in[0][0][0] = 32'd5;
    data_in[1][0][0] = -32'd3;
    data_in[2][0][0] = 32'd7;
    d0 = done_seen;
    start_tile(4, 3);
    run_idle(100);
    chk("s1_accepts", k, 12);
    chk("s1_pops", pops, 4);
    chk("s1_done_once", done_seen - d0, 1);
    chk("s1_lane0_sum", first_pop[0], 32'd9);
    chk("s1_acc_empty", accq.size(), 0);

    // S2: rows=16, passes=1, consumer stalled until the tile is accumulated
    rdy_mode = 2;
    set_data();
    d0 = done_seen;
    start_tile(16, 1);
    run_accepts(16, 40);
    repeat (3) cycle();
    chk("s2_ob_full", outq.size(), 16);
    chk("s2_busy", busy, 1);
    chk("s2_no_done", done_seen - d0, 0);
    rdy_mode = 0;
    run_idle(60);
    chk("s2_pops", pops, 16);
    chk("s2_done_once", done_seen - d0, 1);

    // S3: illegal starts
    for (int i = 0; i < 3; i++) begin
      cfg_rows   = (i == 0) ? 5'd0 : (i == 1) ? 5'd17 : 5'd4;
      cfg_passes = (i == 2) ? 8'd0 : 8'd2;
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("s3_cfg_err", cfg_err, 1);
      chk("s3_in_ready", in_ready, 0);
      chk("s3_busy", busy, 0);
      cycle();
    end

    // S4: rows=2, passes=2, toggling input, random consumer
    in_mode = 1; tog = 1'b1; rdy_mode = 1;
    set_data();
    d0 = done_seen;
    start_tile(2, 2);
    run_idle(200);
    chk("s4_accepts", k, 4);
    chk("s4_pops", pops, 2);
    chk("s4_done_once", done_seen - d0, 1);
    chk("s4_acc_empty", accq.size(), 0);

    // S5: asynchronous reset at pass 1, row 1
    in_mode = 0; rdy_mode = 0;
    set_data();
    start_tile(3, 3);
    run_accepts(4, 20);
    #2 rst = 1'b0;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_in_ready", in_ready, 0);
    chk("s5_buf_valid", buf_valid, 0);
    chk("s5_buf_store", buf_store, 0);
    chk("s5_buf_overwrite", buf_overwrite, 0);
    chk("s5_done", done, 0);
    chk("s5_cfg_err", cfg_err, 0);
    chk("s5_out_valid", out_valid, 0);
    chk("s5_buf_rd_en", buf_rd_en, 0);
    m_active = 1'b0; m_err = 1'b0;
    accq.delete();
    outq.delete();
    @(negedge clk);
    d0 = done_seen;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("s5_no_done", done_seen - d0, 0);
    set_data();
    start_tile(3, 1);
    run_idle(40);
    chk("s5_pops", pops, 3);
    chk("s5_done_once", done_seen - d0, 1);

    // S6: start during ACCUM with a different config is ignored
    in_mode = 2; rdy_mode = 1;
    set_data();
    d0 = done_seen;
    start_tile(4, 2);
    run_accepts(3, 60);
    cfg_rows = 5'd5; cfg_passes = 8'd3;
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_idle(300);
    chk("s6_accepts", k, 8);
    chk("s6_pops", pops, 4);
    chk("s6_done_once", done_seen - d0, 1);
    chk("s6_acc_empty", accq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acum_seq_ctrl.md
Name: acum_seq_ctrl

Overview:
- Sequences the accumulation buffer pair for one GEMM output tile:
  - first K-pass: overwrites partial sums;
  - middle passes: read-modify-write accumulate;
  - final pass: accumulates and stores finished rows into the output buffer.
- Generates the buffer's valid/store/overwrite/rd_en controls.
- Provides a ready/valid handshake toward the systolic array and toward the result consumer.
- Sits between the GEMM top-level controller (start/config/done) and the accumulation datapath.

Parameters:
- DEPTH, 16, rows per buffer; maximum cfg_rows.
- RW, 5, width of row config/counters; must hold DEPTH.
- KW, 8, width of pass config/counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  tile start pulse; sampled only in IDLE.
- cfg_rows  in  RW  rows per pass; legal range 1..DEPTH.
- cfg_passes  in  KW  K-passes per tile; legal range 1..2^KW-1.
- busy  out  1  high in ACCUM and DRAIN.
- done  out  1  one-cycle pulse when the tile is fully drained.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- in_valid  in  1  array presents one 4-lane row.
- in_ready  out  1  controller accepts the row.
- buf_valid  out  1  row write strobe to the accumulation buffer.
- buf_store  out  1  route the row to the output buffer.
- buf_overwrite  out  1  bypass accumulation (first pass).
- buf_empty  in  1  output buffer empty flag.
- buf_rd_en  out  1  output buffer pop.
- out_valid  out  1  result row available.
- out_ready  in  1  consumer accepts the row.

Behaviour:

Reset
- All registers clear asynchronously: state=IDLE, counters=0.
- All outputs read 0 during and after reset until the next valid start.
- Reset mid-tile abandons the tile; no done pulse is generated.

States: IDLE, ACCUM, DRAIN.

IDLE
- in_ready=0, busy=0.
- On start with a legal config: latch rows and passes, clear row_cnt/pass_cnt/ob_cnt, go to ACCUM next cycle.
- On start with cfg_rows=0, cfg_rows>DEPTH, or cfg_passes=0: cfg_err=1 for one cycle, remain in IDLE.

ACCUM
- in_ready=1.
- Accept occurs when in_valid & in_ready. On accept, combinationally in the same cycle:
  - buf_valid=1
  - buf_overwrite = (pass_cnt==0)
  - buf_store = (pass_cnt==passes-1)
- A single-pass tile (passes=1) drives overwrite=1 and store=1 together.
- With buf_valid=0, buf_store and buf_overwrite are 0.
- Counter update on accept:
  - row_cnt increments; it wraps to 0 when row_cnt==rows-1, and pass_cnt increments on that wrap.
  - Accept of the last row of the last pass moves to DRAIN.
- Cycles without in_valid are stalls: no counter change, buf_valid=0.

Output side (all states)
- The output buffer is show-ahead.
- out_valid = ~buf_empty.
- buf_rd_en = out_valid & out_ready.
- ob_cnt tracks output-buffer rows:
  - +1 on each buf_valid & buf_store;
  - -1 on each buf_rd_en;
  - both in the same cycle leave it unchanged.
- Rows stream out during the final pass, concurrently with the stores.

DRAIN
- in_ready=0.
- When ob_cnt reaches 0, pulse done=1 and return to IDLE on the same edge.
- Zero-cycle drain: if the consumer pops the last row in the same cycle as its store, ob_cnt is 0 on entry. done then pulses in the first DRAIN cycle.

Protocol rules
- start in ACCUM or DRAIN is ignored; no cfg_err.
- Overflow is structurally impossible (rows ≤ DEPTH, one tile in flight).
- The accumulation buffer is read exactly once per row on every non-first pass. It is therefore empty at done.

Latency
- start→first possible accept: 1 cycle.
- Last-row accept→done: ≥1 cycle, bounded by consumer stalls.

Test Plan:
1. rows=4, passes=3; in_valid held high; out_ready=1.
   - Required: 12 accepts, with overwrite=1 on accepts 0–3, 0 on 4–11; store=1 on accepts 8–11 only.
   - Required: 4 rows out; done exactly once; accumulated value = sum of the three per-pass inputs per lane, e.g. 5 + (-3) + 7 = 9.
2. rows=16, passes=1; out_ready=0 during accumulate.
   - Required: every accept has overwrite=1 and store=1; ob_cnt reaches 16; busy stays 1 and done stays 0.
   - Then assert out_ready: 16 pops, then a done pulse on the next edge.
3. Illegal starts: cfg_rows=0, then cfg_rows=17, then cfg_passes=0.
   - Required: cfg_err pulses each time; state stays IDLE; in_ready=0.
4. rows=2, passes=2 with in_valid toggling 1-0-1-0 and random out_ready.
   - Required: counters advance only on accepts; final outputs match scenario 1 arithmetic.
5. rst driven low mid-ACCUM (pass 1, row 1), asynchronously.
   - Required: all outputs 0 immediately; no done pulse.
   - Then a new start with rows=3, passes=1 completes normally.
6. start pulsed during ACCUM with different cfg.
   - Required: ignored; the original tile completes with its latched config.
